// File: rtl/mux_masters.sv
// Two-master round-robin arbiter onto a single req/ack bus, with read-data return routing.
// Define MUX_MASTERS_FIXED_PRIO_EN to make master 1 win every tie instead of round-robin.
module mux_masters #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         master_1_req,
   input  logic [N-1:0] master_1_addr,
   input  logic         master_1_cmd,
   input  logic [N-1:0] master_1_wdata,
   output logic         master_1_ack,
   output logic [N-1:0] master_1_rdata,
   input  logic         master_2_req,
   input  logic [N-1:0] master_2_addr,
   input  logic         master_2_cmd,
   input  logic [N-1:0] master_2_wdata,
   output logic         master_2_ack,
   output logic [N-1:0] master_2_rdata,
   output logic         slave_req,
   output logic [N-1:0] slave_addr,
   output logic         slave_cmd,
   output logic [N-1:0] slave_wdata,
   input  logic         slave_ack,
   input  logic [N-1:0] slave_rdata
);

   // Master index encoding: 0 = master 1, 1 = master 2.
   logic lock_q, lock_d;
   logic owner_q, owner_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;
   logic gnt_valid, gnt_sel;
   logic gnt_cmd, accept, waiting;

`ifndef MUX_MASTERS_FIXED_PRIO_EN
   logic rr_last_q, rr_last_d;
`endif

   // Grant selection; a lock is honoured only while its owner keeps requesting.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = 1'b0;
      if (lock_q && (owner_q ? master_2_req : master_1_req)) begin
         gnt_valid = 1'b1;
         gnt_sel   = owner_q;
      end else if (master_1_req && master_2_req) begin
         gnt_valid = 1'b1;
`ifdef MUX_MASTERS_FIXED_PRIO_EN
         gnt_sel   = 1'b0;
`else
         gnt_sel   = ~rr_last_q;
`endif
      end else if (master_1_req) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b0;
      end else if (master_2_req) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b1;
      end
   end

   assign gnt_cmd = gnt_sel ? master_2_cmd : master_1_cmd;
   assign accept  = gnt_valid & slave_ack;
   assign waiting = gnt_valid & ~slave_ack;

   always_comb begin
      lock_d     = waiting;
      owner_d    = waiting ? gnt_sel : owner_q;
      rd_pend_d  = accept & ~gnt_cmd;
      rd_owner_d = (accept & ~gnt_cmd) ? gnt_sel : rd_owner_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q     <= 1'b0;
         owner_q    <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         owner_q    <= owner_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

`ifndef MUX_MASTERS_FIXED_PRIO_EN
   assign rr_last_d = accept ? gnt_sel : rr_last_q;

   // Reset to master 2 so master 1 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
`endif

   // All outputs are held at zero while reset is asserted.
   always_comb begin
      slave_req      = 1'b0;
      slave_addr     = '0;
      slave_cmd      = 1'b0;
      slave_wdata    = '0;
      master_1_ack   = 1'b0;
      master_2_ack   = 1'b0;
      master_1_rdata = '0;
      master_2_rdata = '0;
      if (!rst) begin
         if (gnt_valid) begin
            slave_req   = 1'b1;
            slave_addr  = gnt_sel ? master_2_addr : master_1_addr;
            slave_cmd   = gnt_cmd;
            slave_wdata = gnt_sel ? master_2_wdata : master_1_wdata;
         end
         master_1_ack = accept & ~gnt_sel;
         master_2_ack = accept & gnt_sel;
         if (rd_pend_q) begin
            if (rd_owner_q) begin
               master_2_rdata = slave_rdata;
            end else begin
               master_1_rdata = slave_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_masters.sv
// Directed self-checking bench for mux_masters: reset, fairness, lock, read routing, writes.
module tb_mux_masters;

   localparam int unsigned N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         master_1_req, master_1_cmd, master_1_ack;
   logic [N-1:0] master_1_addr, master_1_wdata, master_1_rdata;
   logic         master_2_req, master_2_cmd, master_2_ack;
   logic [N-1:0] master_2_addr, master_2_wdata, master_2_rdata;
   logic         slave_req, slave_cmd, slave_ack;
   logic [N-1:0] slave_addr, slave_wdata, slave_rdata;

   int passed = 0;
   int total  = 0;

   mux_masters #(.N(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .master_1_req   (master_1_req),
      .master_1_addr  (master_1_addr),
      .master_1_cmd   (master_1_cmd),
      .master_1_wdata (master_1_wdata),
      .master_1_ack   (master_1_ack),
      .master_1_rdata (master_1_rdata),
      .master_2_req   (master_2_req),
      .master_2_addr  (master_2_addr),
      .master_2_cmd   (master_2_cmd),
      .master_2_wdata (master_2_wdata),
      .master_2_ack   (master_2_ack),
      .master_2_rdata (master_2_rdata),
      .slave_req      (slave_req),
      .slave_addr     (slave_addr),
      .slave_cmd      (slave_cmd),
      .slave_wdata    (slave_wdata),
      .slave_ack      (slave_ack),
      .slave_rdata    (slave_rdata)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      master_1_req = 1'b0; master_1_addr = '0; master_1_cmd = 1'b0; master_1_wdata = '0;
      master_2_req = 1'b0; master_2_addr = '0; master_2_cmd = 1'b0; master_2_wdata = '0;
      slave_ack = 1'b0; slave_rdata = '0;
   endtask

   // Inputs change 1 time unit after posedge; checks happen on negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      master_1_req = 1'b1; master_2_req = 1'b1;
      master_1_addr = 32'h0000_0011; master_2_addr = 32'h0000_0022;
      slave_ack = 1'b1; slave_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (slave_req !== 1'b0 || master_1_ack !== 1'b0 || master_2_ack !== 1'b0 ||
             slave_addr !== 32'h0)
            $display("FAIL reset_bus[%0d] got req=%0b ack1=%0b ack2=%0b addr=%h want all 0",
                     i, slave_req, master_1_ack, master_2_ack, slave_addr);
         else passed++;
         total++;
         if (master_1_rdata !== 32'h0 || master_2_rdata !== 32'h0)
            $display("FAIL reset_rdata[%0d] got %h/%h want 0/0", i, master_1_rdata,
                     master_2_rdata);
         else passed++;
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1 || master_2_ack !== 1'b0 || slave_addr !== 32'h0000_0011)
         $display("FAIL reset_first_tie got ack1=%0b ack2=%0b addr=%h want 1 0 00000011",
                  master_1_ack, master_2_ack, slave_addr);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_fairness();
      logic exp1;
      apply_reset();
      master_1_req = 1'b1; master_2_req = 1'b1;
      master_1_cmd = 1'b1; master_2_cmd = 1'b1;
      slave_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
`ifdef MUX_MASTERS_FIXED_PRIO_EN
         exp1 = 1'b1;
`else
         exp1 = (i % 2 == 0);
`endif
         @(negedge clk);
         total++;
         if (master_1_ack !== exp1 || master_2_ack !== ~exp1)
            $display("FAIL fairness[%0d] got ack1=%0b ack2=%0b want %0b %0b", i,
                     master_1_ack, master_2_ack, exp1, ~exp1);
         else passed++;
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      apply_reset();
      master_2_req = 1'b1; master_2_addr = 32'h8000_0000; master_2_cmd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            master_1_req = 1'b1; master_1_addr = 32'h0000_1111; master_1_cmd = 1'b1;
         end
         @(negedge clk);
         total++;
         if (slave_addr !== 32'h8000_0000 || master_1_ack !== 1'b0 || master_2_ack !== 1'b0)
            $display("FAIL lock_wait[%0d] got addr=%h ack1=%0b ack2=%0b want 80000000 0 0",
                     i, slave_addr, master_1_ack, master_2_ack);
         else passed++;
         next_cycle();
      end
      slave_ack = 1'b1;
      @(negedge clk);
      total++;
      if (master_2_ack !== 1'b1 || master_1_ack !== 1'b0 || slave_addr !== 32'h8000_0000)
         $display("FAIL lock_accept got ack1=%0b ack2=%0b addr=%h want 0 1 80000000",
                  master_1_ack, master_2_ack, slave_addr);
      else passed++;
      next_cycle();
      master_2_req = 1'b0;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1 || slave_addr !== 32'h0000_1111)
         $display("FAIL lock_handover got ack1=%0b addr=%h want 1 00001111", master_1_ack,
                  slave_addr);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_read_routing();
      apply_reset();
      master_1_req = 1'b1; master_1_cmd = 1'b0; master_1_addr = 32'h0000_0010;
      slave_ack = 1'b1;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1 || slave_cmd !== 1'b0)
         $display("FAIL read_accept got ack1=%0b cmd=%0b want 1 0", master_1_ack, slave_cmd);
      else passed++;
      next_cycle();
      master_1_req = 1'b0;
      master_2_req = 1'b1; master_2_cmd = 1'b1; master_2_wdata = 32'h5555_5555;
      slave_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (master_1_rdata !== 32'hFFFF_FFFF || master_2_rdata !== 32'h0)
         $display("FAIL read_return got %h/%h want ffffffff/00000000", master_1_rdata,
                  master_2_rdata);
      else passed++;
      total++;
      if (master_2_ack !== 1'b1 || slave_wdata !== 32'h5555_5555)
         $display("FAIL read_overlap_write got ack2=%0b wdata=%h want 1 55555555",
                  master_2_ack, slave_wdata);
      else passed++;
      next_cycle();
      idle_inputs();
      slave_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (master_1_rdata !== 32'h0 || master_2_rdata !== 32'h0)
         $display("FAIL read_clear got %h/%h want 0/0", master_1_rdata, master_2_rdata);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_write();
      apply_reset();
      master_2_req = 1'b1; master_2_cmd = 1'b1; master_2_wdata = 32'hA5A5_A5A5;
      slave_ack = 1'b1;
      @(negedge clk);
      total++;
      if (slave_wdata !== 32'hA5A5_A5A5 || slave_cmd !== 1'b1 || master_2_ack !== 1'b1)
         $display("FAIL write_pass got wdata=%h cmd=%0b ack2=%0b want a5a5a5a5 1 1",
                  slave_wdata, slave_cmd, master_2_ack);
      else passed++;
      next_cycle();
      idle_inputs();
      slave_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (master_1_rdata !== 32'h0 || master_2_rdata !== 32'h0 || slave_req !== 1'b0 ||
          slave_wdata !== 32'h0)
         $display("FAIL write_no_rdata got %h/%h req=%0b wdata=%h want 0/0 0 0",
                  master_1_rdata, master_2_rdata, slave_req, slave_wdata);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      master_1_req = 1'b1; master_1_cmd = 1'b0; master_1_addr = 32'h1;
      master_2_req = 1'b1; master_2_cmd = 1'b0; master_2_addr = 32'h2;
      slave_ack = 1'b1;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1 || master_1_rdata !== 32'h0 || master_2_rdata !== 32'h0)
         $display("FAIL b2b_0 got ack1=%0b rdata=%h/%h want 1 0/0", master_1_ack,
                  master_1_rdata, master_2_rdata);
      else passed++;
      next_cycle();
      slave_rdata = 32'h0000_0011;
      @(negedge clk);
      total++;
      if (master_2_ack !== 1'b1 || master_1_rdata !== 32'h11 || master_2_rdata !== 32'h0)
         $display("FAIL b2b_1 got ack2=%0b rdata=%h/%h want 1 11/0", master_2_ack,
                  master_1_rdata, master_2_rdata);
      else passed++;
      next_cycle();
      slave_rdata = 32'h0000_0022;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1 || master_2_rdata !== 32'h22 || master_1_rdata !== 32'h0)
         $display("FAIL b2b_2 got ack1=%0b rdata=%h/%h want 1 0/22", master_1_ack,
                  master_1_rdata, master_2_rdata);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      master_1_req = 1'b1; master_1_cmd = 1'b0;
      slave_ack = 1'b1;
      @(negedge clk);
      total++;
      if (master_1_ack !== 1'b1)
         $display("FAIL rmr_accept got ack1=%0b want 1", master_1_ack);
      else passed++;
      next_cycle();
      rst = 1'b1;
      slave_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (master_1_rdata !== 32'h0 || master_1_ack !== 1'b0 || slave_req !== 1'b0)
         $display("FAIL rmr_during got rdata=%h ack1=%0b req=%0b want 0 0 0",
                  master_1_rdata, master_1_ack, slave_req);
      else passed++;
      next_cycle();
      rst = 1'b0;
      master_1_req = 1'b0;
      slave_ack = 1'b0;
      @(negedge clk);
      total++;
      if (master_1_rdata !== 32'h0 || master_2_rdata !== 32'h0)
         $display("FAIL rmr_after got %h/%h want 0/0", master_1_rdata, master_2_rdata);
      else passed++;
      next_cycle();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_lock();
      test_read_routing();
      test_write();
      test_back_to_back();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mux_masters.md
# mux_masters

Two-master to one-port round-robin arbiter on the req/ack bus. It sits directly upstream of the slave-side address mux: it consumes requests from master 1 and master 2 and drives a single master-side bus into that mux. It also routes the one-cycle-delayed read data and the per-cycle ack back to the master that owns each transaction.

## Interface
- N, 32, address and data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- master_1_req / master_2_req  in  1  request from master 1 / 2
- master_1_addr / master_2_addr  in  N  address
- master_1_cmd / master_2_cmd  in  1  1 = write, 0 = read
- master_1_wdata / master_2_wdata  in  N  write data
- master_1_ack / master_2_ack  out  1  transaction accepted
- master_1_rdata / master_2_rdata  out  N  read data
- slave_req  out  1  forwarded request to the downstream mux
- slave_addr, slave_cmd, slave_wdata  out  N/1/N  forwarded from the granted master
- slave_ack  in  1  acceptance from downstream
- slave_rdata  in  N  read data, valid the cycle after a read is accepted

## Operation
- Handshake:
  - A transaction is accepted in any cycle where req=1 and ack=1.
  - The master holds addr, cmd and wdata stable until it sees ack.
- Registered state:
  - lock: grant is frozen.
  - owner: the locked master.
  - rr_last: the master most recently accepted.
  - rd_pend: a read is in flight.
  - rd_owner: the master that issued the in-flight read.
- Granted master gm, evaluated combinationally each cycle:
  - If lock=1 and master[owner]_req=1: gm = owner.
  - Else if only one master requests: gm = that master.
  - Else if both request: gm = the master that is not rr_last.
  - Else: no grant.
- When a grant exists, slave_req, slave_addr, slave_cmd and slave_wdata equal master[gm]'s signals.
- When no grant exists, slave_req=0 and slave_addr, slave_cmd and slave_wdata are 0.
- master[gm]_ack = slave_ack & slave_req. The other master's ack is always 0.
- Wait cycle (slave_req=1, slave_ack=0): lock<=1, owner<=gm. The grant does not switch to the other master while the owner waits.
- Acceptance (slave_req=1, slave_ack=1):
  - lock<=0 and rr_last<=gm.
  - If cmd=0: rd_pend<=1, rd_owner<=gm.
  - If cmd=1: rd_pend<=0.
- Read return:
  - When rd_pend=1, master[rd_owner]_rdata = slave_rdata and the other master's rdata = 0.
  - When rd_pend=0, both rdata outputs are 0.
  - rd_pend clears the next cycle unless a new read is accepted in that cycle.
- Back-to-back transactions:
  - A new acceptance may occur in the same cycle that the previous read data returns. There is no bubble.
  - After each acceptance the other master wins any tie.
- Owner drops req while lock=1 (protocol violation): the lock is ignored that cycle and arbitration runs normally. lock clears on the next edge.

## Timing
- Request path is combinational: slave_req follows master req in the same cycle, with zero-cycle arbitration latency.
- Ack path is combinational.
- Read data reaches the master 1 cycle after the acceptance edge.
- Reset values (rst=1 on an edge): lock=0, owner=0, rr_last=master 2 (so master 1 wins the first tie), rd_pend=0, rd_owner=0.
- While rst=1, all outputs are forced to 0: both acks, both rdata, slave_req, slave_addr, slave_cmd, slave_wdata.
- Reset mid-operation drops any pending read. No rdata is delivered after reset deasserts.
- Simultaneous request from the non-owner during the owner's wait: the non-owner stays ack=0 until the owner is accepted, then it is granted in the next cycle.

## Configuration
- MUX_MASTERS_FIXED_PRIO_EN defined:
  - Ties always go to master 1, and rr_last is not used.
  - Lock still prevents switching while the owner waits.
- MUX_MASTERS_FIXED_PRIO_EN undefined: round-robin as described above.

## Test plan
- Reset and idle: rst=1 for 4 cycles with both masters requesting -> slave_req=0, both acks 0, both rdata 0. After release with slave_ack=1 -> master 1 is accepted first.
- Fairness:
  - Stimulus: both masters request continuously with slave_ack=1.
  - Expected: accepts alternate 1,2,1,2 over 8 cycles.
  - With MUX_MASTERS_FIXED_PRIO_EN, all 8 accepts go to master 1.
- Lock during wait:
  - Stimulus: master 2 requests with addr=32'h8000_0000 and slave_ack=0 for 3 cycles; master 1 asserts req in cycle 2.
  - Expected: slave_addr stays 32'h8000_0000 and master_1_ack stays 0 through the wait.
  - Expected: master 1 is granted in the cycle after master 2's ack.
- Read routing:
  - Stimulus: master 1 read accepted, then slave_rdata=32'hFFFF_FFFF on the next cycle.
  - Expected: master_1_rdata=32'hFFFF_FFFF and master_2_rdata=0.
  - Expected: a master 2 write accepted in that same cycle does not disturb master_1_rdata.
- Write passthrough: master 2 write with cmd=1, wdata=32'hA5A5_A5A5, accepted -> slave_wdata=32'hA5A5_A5A5 that cycle, and both rdata stay 0 the next cycle.
- Reset mid-read: read accepted, then rst=1 on the next edge -> both rdata are 0 and rd_pend is 0 after reset.
